seg_bcd_counter_scan: RTL and testbench

//   Multi-digit BCD up/down counter with time-multiplexed 7-segment output.
//   A parametrised prescaler produces the count tick and a separate scan

---
 rtl/seg_bcd_counter_scan_if.sv | 29 ++
 rtl/seg_bcd_counter_scan.sv | 168 ++++++++++++++++
 tb/tb_seg_bcd_counter_scan.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_bcd_counter_scan_if.sv
// Control and display bundle for seg_bcd_counter_scan.
// The master side drives count controls; the slave side returns count and display state.
interface seg_bcd_counter_scan_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    en;
  logic                    up;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    blank_lz;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    wrap;
  logic                    err;
  logic [SEL_W-1:0]        sel;
  logic [3:0]              mul_out;
  logic [7:0]              seg;

  modport master (
    output en, up, load, load_val, blank_lz,
    input  count_bcd, wrap, err, sel, mul_out, seg
  );

  modport slave (
    input  en, up, load, load_val, blank_lz,
    output count_bcd, wrap, err, sel, mul_out, seg
  );
endinterface

// File: rtl/seg_bcd_counter_scan.sv
// Multi-digit BCD up/down counter with prescaled tick, load with validity check,
// and a time-multiplexed 7-segment scan with leading-zero blanking.
module seg_bcd_counter_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50,
  parameter int SCAN_DIV   = 1000,
  parameter int MAX_COUNT  = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_bcd_counter_scan_if.slave bus
);
  localparam int SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW     = 4 * NUM_DIGITS;
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  function automatic logic [DW-1:0] to_bcd(input int unsigned v);
    logic [DW-1:0] r;
    int unsigned   t;
    r = '0;
    t = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [DW-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  logic [PRE_W-1:0]  pre_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DW-1:0]     count_q;
  logic              wrap_q;
  logic              err_q;
  logic [SEL_W-1:0]  sel_q;
  logic [3:0]        mul_q;

  logic              tick;
  logic              scan_step;
  logic              load_ok;
  logic [31:0]       load_bin;
  logic [DW-1:0]     count_inc;
  logic [DW-1:0]     count_dec;
  logic              carry;
  logic              borrow;
  logic [SEL_W-1:0]  sel_next;
  logic              hi_zero;
  logic [7:0]        seg_digit;
  logic [7:0]        seg_c;

  assign tick      = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign scan_step = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign sel_next  = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);

  // Load is legal only if every nibble is a decimal digit and the value fits the range.
  always_comb begin
    load_ok  = 1'b1;
    load_bin = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (bus.load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      load_bin = load_bin * 32'd10 + 32'(bus.load_val[4*i +: 4]);
    end
    if (load_bin > 32'(MAX_COUNT)) load_ok = 1'b0;
  end

  always_comb begin
    count_inc = count_q;
    count_dec = count_q;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      scan_cnt <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= '0;
      mul_q    <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      wrap_q  <= 1'b0;
      if (bus.load) begin
        count_q <= load_ok ? bus.load_val : '0;
        err_q   <= ~load_ok;
      end else if (tick && bus.en) begin
        if (bus.up) begin
          if (count_q == MAX_BCD) begin
            count_q <= '0;
            wrap_q  <= 1'b1;
          end else begin
            count_q <= count_inc;
          end
        end else begin
          if (count_q == '0) begin
            count_q <= MAX_BCD;
            wrap_q  <= 1'b1;
          end else begin
            count_q <= count_dec;
          end
        end
      end
      // mul_out tracks the digit that sel will point at after this edge.
      if (scan_step) begin
        scan_cnt <= '0;
        sel_q    <= sel_next;
        mul_q    <= count_q[4*sel_next +: 4];
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
        mul_q    <= count_q[4*sel_q +: 4];
      end
    end
  end

  assign hi_zero = ((count_q >> (4 * sel_q)) == '0);

  always_comb begin
    case (mul_q)
      4'd0:    seg_digit = 8'h3F;
      4'd1:    seg_digit = 8'h06;
      4'd2:    seg_digit = 8'h5B;
      4'd3:    seg_digit = 8'h4F;
      4'd4:    seg_digit = 8'h66;
      4'd5:    seg_digit = 8'h6D;
      4'd6:    seg_digit = 8'h7D;
      4'd7:    seg_digit = 8'h07;
      4'd8:    seg_digit = 8'h7F;
      4'd9:    seg_digit = 8'h6F;
      default: seg_digit = 8'h79;
    endcase
    if (err_q) begin
      seg_c = 8'h79;
    end else if (bus.blank_lz && (sel_q != '0) && hi_zero) begin
      seg_c = 8'h00;
    end else begin
      seg_c = seg_digit;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;
  assign bus.sel       = sel_q;
  assign bus.mul_out   = mul_q;
  assign bus.seg       = seg_c;
endmodule

// File: tb/tb_seg_bcd_counter_scan.sv
// Bench for seg_bcd_counter_scan: directed scenarios plus randomized traffic
// compared against a decimal-arithmetic reference model.
module tb_seg_bcd_counter_scan;
  localparam int ND   = 4;
  localparam int TD   = 5;
  localparam int SD   = 7;
  localparam int MAXC = 9999;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_bcd_counter_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_bcd_counter_scan #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .MAX_COUNT(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] seg_tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Reference model state: plain decimal integers.
  int m_pre, m_cnt, m_scan, m_sel, m_mul;
  bit m_err, m_wrap;

  function automatic int pow10(int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit load_legal(logic [4*ND-1:0] v);
    int val = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
      val = val * 10 + int'(v[4*i +: 4]);
    end
    return val <= MAXC;
  endfunction

  function automatic int load_value(logic [4*ND-1:0] v);
    int val = 0;
    for (int i = ND - 1; i >= 0; i--) val = val * 10 + int'(v[4*i +: 4]);
    return val;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(int v);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic bit tick_now();
    return m_pre == TD - 1;
  endfunction

  function automatic int next_cnt();
    if (bus.load) return load_legal(bus.load_val) ? load_value(bus.load_val) : 0;
    if (tick_now() && bus.en) begin
      if (bus.up) return (m_cnt == MAXC) ? 0 : m_cnt + 1;
      return (m_cnt == 0) ? MAXC : m_cnt - 1;
    end
    return m_cnt;
  endfunction

  function automatic bit next_err();
    if (bus.load) return !load_legal(bus.load_val);
    return m_err;
  endfunction

  function automatic bit next_wrap();
    if (bus.load || !(tick_now() && bus.en)) return 1'b0;
    return bus.up ? (m_cnt == MAXC) : (m_cnt == 0);
  endfunction

  function automatic int next_sel();
    return (m_scan == SD - 1) ? (m_sel + 1) % ND : m_sel;
  endfunction

  function automatic logic [7:0] exp_seg();
    if (m_err) return 8'h79;
    if (bus.blank_lz && m_sel > 0 && (m_cnt / pow10(m_sel)) == 0) return 8'h00;
    if (m_mul > 9) return 8'h79;
    return seg_tbl[m_mul];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre  <= 0;
      m_cnt  <= 0;
      m_scan <= 0;
      m_sel  <= 0;
      m_mul  <= 0;
      m_err  <= 1'b0;
      m_wrap <= 1'b0;
    end else begin
      m_cnt  <= next_cnt();
      m_err  <= next_err();
      m_wrap <= next_wrap();
      m_pre  <= (m_pre + 1) % TD;
      m_scan <= (m_scan + 1) % SD;
      m_sel  <= next_sel();
      m_mul  <= (m_cnt / pow10(next_sel())) % 10;
    end
  end

  task automatic do_load(input logic [4*ND-1:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_tick_cycle();
    int g = 0;
    while (!tick_now() && g < TD + 2) begin
      @(negedge clk);
      g++;
    end
    if (!tick_now()) begin
      failures++;
      $display("FAIL tick_timeout: no tick within %0d cycles", TD + 2);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      wait_tick_cycle();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.en = 0; bus.up = 1; bus.load = 0; bus.load_val = '0; bus.blank_lz = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5 * TD; c++) begin
      @(negedge clk);
      checks++;
      if (bus.count_bcd !== 16'h0000 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: count=%h wrap=%b err=%b, want 0000/0/0",
                 bus.count_bcd, bus.wrap, bus.err);
      end
      checks++;
      if (bus.seg !== 8'h3F) begin
        failures++;
        $display("FAIL reset_seg: sel=%0d seg=%h, want 3f", bus.sel, bus.seg);
      end
    end
  endtask

  task automatic test_up_wrap();
    bus.en = 0;
    do_load(16'h9998);
    bus.en = 1; bus.up = 1;
    wait_ticks(1);
    checks++;
    if (bus.count_bcd !== 16'h9999 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL up_9999: count=%h wrap=%b, want 9999/0", bus.count_bcd, bus.wrap);
    end
    wait_ticks(1);
    checks++;
    if (bus.count_bcd !== 16'h0000 || bus.wrap !== 1'b1) begin
      failures++;
      $display("FAIL up_wrap: count=%h wrap=%b, want 0000/1", bus.count_bcd, bus.wrap);
    end
    @(negedge clk);
    checks++;
    if (bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL up_wrap_pulse: wrap=%b one cycle later, want 0", bus.wrap);
    end
    bus.en = 0;
  endtask

  task automatic test_down_borrow();
    bus.en = 0;
    do_load(16'h0100);
    bus.en = 1; bus.up = 0;
    wait_ticks(1);
    checks++;
    if (bus.count_bcd !== 16'h0099 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL down_borrow: count=%h wrap=%b, want 0099/0", bus.count_bcd, bus.wrap);
    end
    bus.en = 0;
    do_load(16'h0000);
    bus.en = 1;
    wait_ticks(1);
    checks++;
    if (bus.count_bcd !== 16'h9999 || bus.wrap !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap: count=%h wrap=%b, want 9999/1", bus.count_bcd, bus.wrap);
    end
    bus.en = 0;
  endtask

  task automatic test_illegal_load();
    bit [ND-1:0] seen = '0;
    bus.en = 0; bus.blank_lz = 1;
    do_load(16'h12A4);
    checks++;
    if (bus.count_bcd !== 16'h0000 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_load: count=%h err=%b, want 0000/1", bus.count_bcd, bus.err);
    end
    for (int c = 0; c < ND * SD + 2; c++) begin
      @(negedge clk);
      seen[bus.sel] = 1'b1;
      checks++;
      if (bus.seg !== 8'h79) begin
        failures++;
        $display("FAIL err_seg: sel=%0d seg=%h, want 79", bus.sel, bus.seg);
      end
    end
    checks++;
    if (seen !== {ND{1'b1}}) begin
      failures++;
      $display("FAIL err_scan_cover: sels seen=%b, want all", seen);
    end
    do_load(16'h0042);
    checks++;
    if (bus.count_bcd !== 16'h0042 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL legal_reload: count=%h err=%b, want 0042/0", bus.count_bcd, bus.err);
    end
  endtask

  task automatic scan_pass(input bit blank, input logic [7:0] want [ND]);
    int s0;
    int prev;
    int g = 0;
    bus.blank_lz = blank;
    repeat (2) @(negedge clk);
    prev = int'(bus.sel);
    while (int'(bus.sel) == prev && g < SD + 2) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (int'(bus.sel) == prev) begin
      failures++;
      $display("FAIL scan_timeout: sel stuck at %0d", prev);
    end
    s0 = int'(bus.sel);
    for (int c = 0; c < ND * SD; c++) begin
      int es;
      if (c > 0) @(negedge clk);
      es = (s0 + c / SD) % ND;
      checks++;
      if (int'(bus.sel) !== es || bus.seg !== want[es]) begin
        failures++;
        $display("FAIL scan_blank%0d: cyc=%0d sel=%0d seg=%h, want sel=%0d seg=%h",
                 blank, c, bus.sel, bus.seg, es, want[es]);
      end
    end
  endtask

  task automatic test_scan_blank();
    logic [7:0] w_blank [ND] = '{8'h5B, 8'h66, 8'h00, 8'h00};
    logic [7:0] w_full  [ND] = '{8'h5B, 8'h66, 8'h3F, 8'h3F};
    bus.en = 0;
    do_load(16'h0042);
    scan_pass(1'b1, w_blank);
    scan_pass(1'b0, w_full);
  endtask

  task automatic test_priority();
    bus.en = 1; bus.up = 1;
    do_load(16'h0005);
    wait_tick_cycle();
    do_load(16'h0300);
    checks++;
    if (bus.count_bcd !== 16'h0300 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL prio_load: count=%h wrap=%b, want 0300/0", bus.count_bcd, bus.wrap);
    end
    do_load(16'h9999);
    wait_tick_cycle();
    do_load(16'h9999);
    checks++;
    if (bus.count_bcd !== 16'h9999 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL prio_nowrap: count=%h wrap=%b, want 9999/0", bus.count_bcd, bus.wrap);
    end
    bus.en = 0;
  endtask

  task automatic test_async_reset();
    bus.en = 0; bus.up = 1;
    do_load(16'hA000);
    bus.en = 1;
    wait_ticks(2);
    checks++;
    if (bus.count_bcd !== 16'h0002 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: count=%h err=%b, want 0002/1", bus.count_bcd, bus.err);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.count_bcd !== 16'h0000 || bus.err !== 1'b0 || bus.wrap !== 1'b0 ||
        bus.sel !== '0 || bus.mul_out !== 4'd0 || bus.seg !== 8'h3F) begin
      failures++;
      $display("FAIL async_rst: count=%h err=%b wrap=%b sel=%0d mul=%0d seg=%h, want 0000/0/0/0/0/3f",
               bus.count_bcd, bus.err, bus.wrap, bus.sel, bus.mul_out, bus.seg);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (TD - 1) @(negedge clk);
    checks++;
    if (bus.count_bcd !== 16'h0000) begin
      failures++;
      $display("FAIL rst_early_tick: count=%h, want 0000", bus.count_bcd);
    end
    @(negedge clk);
    checks++;
    if (bus.count_bcd !== 16'h0001) begin
      failures++;
      $display("FAIL rst_first_tick: count=%h, want 0001", bus.count_bcd);
    end
    bus.en = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 900; c++) begin
      int r;
      @(negedge clk);
      checks++;
      if (bus.count_bcd !== to_bcd(m_cnt) || bus.wrap !== m_wrap || bus.err !== m_err) begin
        failures++;
        $display("FAIL rand_count: cyc=%0d count=%h wrap=%b err=%b, want %h/%b/%b",
                 c, bus.count_bcd, bus.wrap, bus.err, to_bcd(m_cnt), m_wrap, m_err);
      end
      checks++;
      if (int'(bus.sel) !== m_sel || int'(bus.mul_out) !== m_mul || bus.seg !== exp_seg()) begin
        failures++;
        $display("FAIL rand_display: cyc=%0d sel=%0d mul=%0d seg=%h, want %0d/%0d/%h",
                 c, bus.sel, bus.mul_out, bus.seg, m_sel, m_mul, exp_seg());
      end
      r = int'($urandom_range(0, 19));
      bus.load = 1'b0;
      if (r == 0) begin
        bus.load = 1'b1;
        case ($urandom_range(0, 2))
          0:       bus.load_val = to_bcd(MAXC - int'($urandom_range(0, 3)));
          1:       bus.load_val = to_bcd(int'($urandom_range(0, 3)));
          default: bus.load_val = to_bcd(int'($urandom_range(0, MAXC)));
        endcase
      end else if (r == 1) begin
        bus.load     = 1'b1;
        bus.load_val = 16'($urandom);
      end
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 40) == 0) bus.up = ~bus.up;
      if ($urandom_range(0, 25) == 0) bus.blank_lz = ~bus.blank_lz;
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_illegal_load();
    test_scan_blank();
    test_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
